// File: rtl/param_stager_pkg.sv
// Shared definitions for the parameter stager: address map, field widths,
// FSM state encoding and bank read/write helpers.
package param_stager_pkg;

    localparam int W_ADDR = 4;
    localparam int W_DATA = 32;

    localparam int W_CMOS  = 16;
    localparam int W_LASER = 32;
    localparam int W_GATE  = 32;
    localparam int W_STEP  = 8;
    localparam int W_DECI  = 16;

    localparam int NUM_PARAMS = 11;

    localparam logic [W_ADDR-1:0] ADDR_CMOS_FREQ          = 4'd0;
    localparam logic [W_ADDR-1:0] ADDR_CMOS_WIDTH         = 4'd1;
    localparam logic [W_ADDR-1:0] ADDR_LASER_FREQ         = 4'd2;
    localparam logic [W_ADDR-1:0] ADDR_LASER_WIDTH        = 4'd3;
    localparam logic [W_ADDR-1:0] ADDR_FRAME_GATE_WIDTH_A = 4'd4;
    localparam logic [W_ADDR-1:0] ADDR_FRAME_GATE_DELAY_A = 4'd5;
    localparam logic [W_ADDR-1:0] ADDR_FRAME_GATE_WIDTH_B = 4'd6;
    localparam logic [W_ADDR-1:0] ADDR_FRAME_GATE_DELAY_B = 4'd7;
    localparam logic [W_ADDR-1:0] ADDR_TIM_CYCLES_M       = 4'd8;
    localparam logic [W_ADDR-1:0] ADDR_DELAY_STEP_DELTA_T = 4'd9;
    localparam logic [W_ADDR-1:0] ADDR_BG_FRAME_DECI_N    = 4'd10;
    localparam logic [W_ADDR-1:0] ADDR_LIMIT              = 4'(NUM_PARAMS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GUARD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [W_CMOS-1:0]  cmos_freq;
        logic [W_CMOS-1:0]  cmos_width;
        logic [W_LASER-1:0] laser_freq;
        logic [W_LASER-1:0] laser_width;
        logic [W_GATE-1:0]  frame_gate_width_a;
        logic [W_GATE-1:0]  frame_gate_delay_a;
        logic [W_GATE-1:0]  frame_gate_width_b;
        logic [W_GATE-1:0]  frame_gate_delay_b;
        logic [W_STEP-1:0]  tim_cycles_m;
        logic [W_STEP-1:0]  delay_step_delta_t;
        logic [W_DECI-1:0]  bg_frame_deci_n;
    } param_bank_t;

    // Narrow fields keep the LSBs of the write word; unmapped addresses leave the bank untouched.
    function automatic param_bank_t bank_write(input param_bank_t bank,
                                               input logic [W_ADDR-1:0] addr,
                                               input logic [W_DATA-1:0] data);
        param_bank_t nxt;
        nxt = bank;
        case (addr)
            ADDR_CMOS_FREQ:          nxt.cmos_freq          = data[W_CMOS-1:0];
            ADDR_CMOS_WIDTH:         nxt.cmos_width         = data[W_CMOS-1:0];
            ADDR_LASER_FREQ:         nxt.laser_freq         = data[W_LASER-1:0];
            ADDR_LASER_WIDTH:        nxt.laser_width        = data[W_LASER-1:0];
            ADDR_FRAME_GATE_WIDTH_A: nxt.frame_gate_width_a = data[W_GATE-1:0];
            ADDR_FRAME_GATE_DELAY_A: nxt.frame_gate_delay_a = data[W_GATE-1:0];
            ADDR_FRAME_GATE_WIDTH_B: nxt.frame_gate_width_b = data[W_GATE-1:0];
            ADDR_FRAME_GATE_DELAY_B: nxt.frame_gate_delay_b = data[W_GATE-1:0];
            ADDR_TIM_CYCLES_M:       nxt.tim_cycles_m       = data[W_STEP-1:0];
            ADDR_DELAY_STEP_DELTA_T: nxt.delay_step_delta_t = data[W_STEP-1:0];
            ADDR_BG_FRAME_DECI_N:    nxt.bg_frame_deci_n    = data[W_DECI-1:0];
            default: ;
        endcase
        return nxt;
    endfunction

    function automatic logic [W_DATA-1:0] bank_read(input param_bank_t bank,
                                                    input logic [W_ADDR-1:0] addr);
        logic [W_DATA-1:0] val;
        val = '0;
        case (addr)
            ADDR_CMOS_FREQ:          val = 32'(bank.cmos_freq);
            ADDR_CMOS_WIDTH:         val = 32'(bank.cmos_width);
            ADDR_LASER_FREQ:         val = bank.laser_freq;
            ADDR_LASER_WIDTH:        val = bank.laser_width;
            ADDR_FRAME_GATE_WIDTH_A: val = bank.frame_gate_width_a;
            ADDR_FRAME_GATE_DELAY_A: val = bank.frame_gate_delay_a;
            ADDR_FRAME_GATE_WIDTH_B: val = bank.frame_gate_width_b;
            ADDR_FRAME_GATE_DELAY_B: val = bank.frame_gate_delay_b;
            ADDR_TIM_CYCLES_M:       val = 32'(bank.tim_cycles_m);
            ADDR_DELAY_STEP_DELTA_T: val = 32'(bank.delay_step_delta_t);
            ADDR_BG_FRAME_DECI_N:    val = 32'(bank.bg_frame_deci_n);
            default:                 val = '0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/param_stager_if.sv
// Host-side write/commit bus of the parameter stager together with its
// status strobes and the load_param pulse seen by the consumer.
interface param_stager_if;
    import param_stager_pkg::*;

    logic              wr_en;
    logic [W_ADDR-1:0] wr_addr;
    logic [W_DATA-1:0] wr_data;
    logic              commit;
    logic              addr_err;
    logic              busy;
    logic              commit_done;
    logic              load_param;

    modport master (
        output wr_en, wr_addr, wr_data, commit,
        input  addr_err, busy, commit_done, load_param
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit,
        output addr_err, busy, commit_done, load_param
    );

endinterface

// File: rtl/param_stager_fsm.sv
// Commit sequencer: IDLE -> ASSERT (load_param high) -> GUARD (low, commit_done
// on the last cycle), with a one-deep pending flag for commits arriving while busy.
module param_stager_fsm
    import param_stager_pkg::*;
#(
    parameter int unsigned LOAD_HI_CYCLES = 4,
    parameter int unsigned LOAD_LO_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic commit_i,
    output logic start_o,
    output logic load_param_o,
    output logic busy_o,
    output logic commit_done_o
);

    localparam logic [7:0] HI_LAST = 8'(LOAD_HI_CYCLES - 1);
    localparam logic [7:0] LO_LAST = 8'(LOAD_LO_CYCLES - 1);
    localparam logic [7:0] LO_DONE = 8'(LOAD_LO_CYCLES - 2);

    state_t     state_q;
    logic [7:0] phase_q;
    logic       pending_q;
    logic       load_param_q;
    logic       busy_q;
    logic       commit_done_q;
    logic       start;

    assign start = (state_q == IDLE) && (commit_i || pending_q);

    // busy stays high through the IDLE gap before a pending commit is serviced,
    // so back-to-back sequences look like one continuous busy window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            pending_q     <= 1'b0;
            load_param_q  <= 1'b0;
            busy_q        <= 1'b0;
            commit_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    commit_done_q <= 1'b0;
                    phase_q       <= '0;
                    if (start) begin
                        state_q      <= ASSERT;
                        load_param_q <= 1'b1;
                        busy_q       <= 1'b1;
                        pending_q    <= 1'b0;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ASSERT: begin
                    if (commit_i) pending_q <= 1'b1;
                    if (phase_q == HI_LAST) begin
                        state_q      <= GUARD;
                        phase_q      <= '0;
                        load_param_q <= 1'b0;
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end
                GUARD: begin
                    if (commit_i) pending_q <= 1'b1;
                    if (phase_q == LO_LAST) begin
                        state_q       <= IDLE;
                        phase_q       <= '0;
                        commit_done_q <= 1'b0;
                        busy_q        <= pending_q || commit_i;
                    end else begin
                        phase_q       <= phase_q + 8'd1;
                        commit_done_q <= (phase_q == LO_DONE);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign start_o       = start;
    assign load_param_o  = load_param_q;
    assign busy_o        = busy_q;
    assign commit_done_o = commit_done_q;

endmodule

// File: rtl/param_stager.sv
// Parameter stager top: shadow/active banks, address decode and the commit FSM.
// Optional register readback port is built when PARAM_STAGER_READBACK_EN is defined.
module param_stager
    import param_stager_pkg::*;
#(
    parameter int unsigned LOAD_HI_CYCLES = 4,
    parameter int unsigned LOAD_LO_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef PARAM_STAGER_READBACK_EN
    input  logic                rd_en,
    input  logic [W_ADDR-1:0]   rd_addr,
    input  logic                rd_sel,
    output logic [W_DATA-1:0]   rd_data,
    output logic                rd_valid,
`endif
    param_stager_if.slave       bus,
    output logic [W_CMOS-1:0]   cmos_freq_o,
    output logic [W_CMOS-1:0]   cmos_width_o,
    output logic [W_LASER-1:0]  laser_freq_o,
    output logic [W_LASER-1:0]  laser_width_o,
    output logic [W_GATE-1:0]   frame_gate_width_a_o,
    output logic [W_GATE-1:0]   frame_gate_delay_a_o,
    output logic [W_GATE-1:0]   frame_gate_width_b_o,
    output logic [W_GATE-1:0]   frame_gate_delay_b_o,
    output logic [W_STEP-1:0]   tim_cycles_m_o,
    output logic [W_STEP-1:0]   delay_step_delta_t_o,
    output logic [W_DECI-1:0]   bg_frame_deci_n_o
);

    param_bank_t shadow_q;
    param_bank_t shadow_d;
    param_bank_t active_q;
    logic        addr_err_q;
    logic        start;

    param_stager_fsm #(
        .LOAD_HI_CYCLES (LOAD_HI_CYCLES),
        .LOAD_LO_CYCLES (LOAD_LO_CYCLES)
    ) u_fsm (
        .clk           (clk),
        .rst_n         (rst_n),
        .commit_i      (bus.commit),
        .start_o       (start),
        .load_param_o  (bus.load_param),
        .busy_o        (bus.busy),
        .commit_done_o (bus.commit_done)
    );

    always_comb begin
        shadow_d = shadow_q;
        if (bus.wr_en) shadow_d = bank_write(shadow_q, bus.wr_addr, bus.wr_data);
    end

    // The active bank snapshots shadow_d, so a write in the commit cycle is published.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q   <= '0;
            active_q   <= '0;
            addr_err_q <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            addr_err_q <= bus.wr_en && (bus.wr_addr >= ADDR_LIMIT);
            if (start) active_q <= shadow_d;
        end
    end

    assign bus.addr_err = addr_err_q;

    assign cmos_freq_o          = active_q.cmos_freq;
    assign cmos_width_o         = active_q.cmos_width;
    assign laser_freq_o         = active_q.laser_freq;
    assign laser_width_o        = active_q.laser_width;
    assign frame_gate_width_a_o = active_q.frame_gate_width_a;
    assign frame_gate_delay_a_o = active_q.frame_gate_delay_a;
    assign frame_gate_width_b_o = active_q.frame_gate_width_b;
    assign frame_gate_delay_b_o = active_q.frame_gate_delay_b;
    assign tim_cycles_m_o       = active_q.tim_cycles_m;
    assign delay_step_delta_t_o = active_q.delay_step_delta_t;
    assign bg_frame_deci_n_o    = active_q.bg_frame_deci_n;

`ifdef PARAM_STAGER_READBACK_EN
    logic [W_DATA-1:0] rd_data_q;
    logic              rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= bank_read(rd_sel ? active_q : shadow_q, rd_addr);
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule
